// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - shared state encoding and default widths for the skid pipeline stage
package pipe_stage_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter, clears only on reset
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE_V = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + ONE_V;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry skid pipeline stage; PIPE_STAGE_PERF_EN enables the stall counter
module pipe_stage_skid
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_t      state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              accept;
  logic              consume;

  // Ready looks only at registered state so out_ready never reaches in_ready.
  assign in_ready  = en && (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign consume   = en && out_valid && out_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (en) begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            main_q <= in_data;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            state  <= TWO;
            skid_q <= in_data;
          end else if (accept) begin
            main_q <= in_data;
          end else if (consume) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .CLK (CLK),
    .nRST(nRST),
    .inc (out_valid && !out_ready && !flush),
    .cnt (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized queue-model bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              en = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] q[$];
  int exp_cnt = 0;

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of traffic: outputs checked mid-cycle, model advanced at the edge.
  task automatic cyc(input logic e, input logic f, input logic iv, input logic ordy,
                     input logic [DATA_W-1:0] d);
    logic acc, con, stl;
    en = e; flush = f; in_valid = iv; out_ready = ordy; in_data = d;
    @(negedge CLK);
    expect_eq("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    expect_eq("in_ready", {31'd0, in_ready}, {31'd0, e && q.size() < 2});
    if (q.size() > 0) expect_eq("out_data", 32'(out_data), 32'(q[0]));
    expect_eq("stall_cnt", 32'(stall_cnt), exp_cnt);
    acc = iv && e && (q.size() < 2);
    con = e && (q.size() > 0) && ordy;
    stl = (q.size() > 0) && !ordy && !f;
    @(posedge CLK);
    #1;
    if (f) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
`ifdef PIPE_STAGE_PERF_EN
    if (stl && exp_cnt < CNT_MAX) exp_cnt++;
`else
    stl = 1'b0;
`endif
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    expect_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    expect_eq("rst_out_data", 32'(out_data), 32'd0);
    expect_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    en = 1'b1;
    nRST = 1'b1;

    // single transfer, latency one cycle
    cyc(1, 0, 1, 1, 8'hA5);
    expect_eq("a5_data", 32'(out_data), 32'hA5);
    expect_eq("a5_valid", {31'd0, out_valid}, 32'd1);
    expect_eq("a5_ready", {31'd0, in_ready}, 32'd1);
    cyc(1, 0, 0, 1, 8'h00);

    // fill both entries under backpressure, then drain
    cyc(1, 0, 1, 0, 8'h11);
    cyc(1, 0, 1, 0, 8'h22);
    expect_eq("two_ready", {31'd0, in_ready}, 32'd0);
    expect_eq("two_head", 32'(out_data), 32'h11);
    cyc(1, 0, 1, 0, 8'h33);
    expect_eq("two_stable", 32'(out_data), 32'h11);
    cyc(1, 0, 0, 1, 8'h00);
    expect_eq("drain_second", 32'(out_data), 32'h22);
    cyc(1, 0, 0, 1, 8'h00);
    expect_eq("drain_empty", {31'd0, out_valid}, 32'd0);

    // flush wins over simultaneous accept and consume
    cyc(1, 0, 1, 0, 8'h44);
    cyc(1, 0, 1, 0, 8'h55);
    cyc(1, 1, 1, 1, 8'h66);
    expect_eq("flush_valid", {31'd0, out_valid}, 32'd0);
    expect_eq("flush_ready", {31'd0, in_ready}, 32'd1);

    // en low freezes everything
    cyc(1, 0, 1, 0, 8'h77);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 1, 8'h88 + 8'(i));
      expect_eq("en0_hold", 32'(out_data), 32'h77);
    end
    cyc(1, 0, 1, 1, 8'h99);
    cyc(1, 0, 0, 1, 8'h00);
    cyc(1, 0, 0, 1, 8'h00);

    // stall run long enough to exercise saturation when counting is built in
    cyc(1, 0, 1, 0, 8'h5A);
    for (int i = 0; i < CNT_MAX + 3; i++) cyc(1, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 1, 8'h00);

    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, 8'($urandom));
    end

    // reset in the middle of traffic discards everything at once
    cyc(1, 0, 1, 0, 8'hC1);
    cyc(1, 0, 1, 0, 8'hC2);
    nRST = 1'b0;
    #1;
    expect_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    expect_eq("mid_rst_data", 32'(out_data), 32'd0);
    expect_eq("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    q.delete();
    exp_cnt = 0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    cyc(1, 0, 1, 1, 8'hD7);
    cyc(1, 0, 0, 1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 128: payload width in bits (min 1).
REQ-002 Parameter CNT_W, default 32: stall-counter width in bits (min 2).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port CLK  input  1  rising-edge clock.
REQ-005 Port nRST  input  1  asynchronous active-low reset.
REQ-006 Port en  input  1  global advance enable (the ihit||dhit equivalent); no transfer occurs while 0.
REQ-007 Port flush  input  1  synchronous discard of all held entries.
REQ-008 Port in_valid  input  1  upstream payload valid.
REQ-009 Port in_data  input  DATA_W  upstream payload.
REQ-010 Port in_ready  output  1  stage can accept this cycle.
REQ-011 Port out_valid  output  1  out_data holds a valid entry.
REQ-012 Port out_data  output  DATA_W  head entry payload.
REQ-013 Port out_ready  input  1  downstream consumes this cycle.
REQ-014 Port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Storage SHALL be a main register plus one skid register; out_data SHALL always come from the main register.
REQ-016 States: EMPTY (no entries), ONE (main valid), TWO (main and skid valid).
REQ-017 in_ready SHALL be en AND (state != TWO); it SHALL be derived from registered state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 in ONE and TWO and 0 in EMPTY, independent of en.
REQ-019 Accept = in_valid AND in_ready; consume = en AND out_valid AND out_ready.
REQ-020 EMPTY: accept -> ONE, with main loaded next edge (latency 1 cycle).
REQ-021 ONE: accept with no consume -> TWO, payload to skid; consume with no accept -> EMPTY; accept with consume -> ONE, main reloaded with in_data.
REQ-022 TWO: consume -> ONE, skid moves to main; no accept is possible.
REQ-023 While en=0, state and both registers SHALL hold, except for flush.
REQ-024 While out_valid=1 and no consume occurs, out_data SHALL remain bit-stable.
REQ-025 Flush SHALL have priority over accept and consume in the same cycle: next state EMPTY, no entry retained, and the simultaneous in_data dropped; flush SHALL act regardless of en.
REQ-026 Payload registers need not be cleared on flush; only the valid state is cleared.
REQ-027 Entries SHALL leave in strict arrival order, and none SHALL be duplicated or lost except by flush.

Reset
REQ-028 Reset SHALL force state EMPTY, out_valid 0, out_data 0, skid payload 0, and stall_cnt 0.
REQ-029 Reset asserted mid-transfer SHALL discard all entries immediately, with no partial update.
REQ-030 in_ready SHALL equal en in the first cycle after reset release.

Configuration
REQ-031 Macro PIPE_STAGE_PERF_EN SHALL control the stall counter.
REQ-032 With PIPE_STAGE_PERF_EN defined, stall_cnt SHALL increment by 1 each cycle that out_valid=1, out_ready=0 and flush=0.
REQ-033 With PIPE_STAGE_PERF_EN defined, stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL clear only on reset.
REQ-034 Without PIPE_STAGE_PERF_EN, the stall_cnt port SHALL remain present and be tied to 0, and no counter flops SHALL be generated.

Structure
REQ-035 pipe_stage_pkg SHALL hold the state typedef (EMPTY/ONE/TWO, 2-bit enum) and the default DATA_W and CNT_W constants.
REQ-036 The saturating counter SHALL be a sub-module, pipe_sat_counter (parameter CNT_W; inputs CLK, nRST, inc), instantiated only under PIPE_STAGE_PERF_EN.

Verification
REQ-037 Reset, then in_valid=1, in_data=0xA5 with en=1, out_ready=1 -> out_valid=1 and out_data=0xA5 on the next cycle; in_ready stays 1.
REQ-038 out_ready=0; push 0x11 then 0x22 -> state TWO, in_ready=0, out_data=0x11 stable; out_ready=1 for two cycles -> out_data 0x11 then 0x22, then out_valid=0.
REQ-039 State TWO plus a simultaneous flush, in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, and no entry is delivered.
REQ-040 en=0 for 5 cycles with in_valid=1 and out_ready=1 -> no transfer, in_ready=0, and out_data unchanged; en=1 -> transfers resume in order.
REQ-041 With PIPE_STAGE_PERF_EN defined and CNT_W=2, 6 stall cycles -> stall_cnt reads 1, 2, 3, 3, 3, 3; without the macro, stall_cnt stays 0.
REQ-042 Random in_valid/out_ready traffic of 10k cycles with a scoreboard -> order preserved, zero loss or duplication, and in_ready never 1 in state TWO.
